// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM state encodings and the word-alignment check.
package mem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [1:0] ALIGN_MASK = 2'b11;

   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Converts a one-cycle load/store from the MEM stage into a req/ack bus
// transaction, stalling the pipeline until the access resolves.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid,
   input  logic                  memread,
   input  logic                  memwrite,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rdata_valid,
   output logic                  err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_inc;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_rdata_valid;
   logic                  r_err;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic                  w_req;
   logic                  w_conflict;
   logic                  w_misaligned;
   logic                  w_legal;
   logic                  w_timeout;
   logic                  w_stall;

   always_comb begin
      w_req        = valid & (memread | memwrite);
      w_conflict   = w_req & memread & memwrite;
      w_misaligned = w_req & ~is_word_aligned(addr[1:0]);
      w_legal      = w_req & ~w_conflict & ~w_misaligned;
      // Counter saturates at TIMEOUT; an ack in the final cycle beats the timeout.
      w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      w_timeout    = (r_state == ACCESS) & ~mem_ack & (w_cnt_inc == CNT_MAX);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_legal) begin
               w_stall     = 1'b1;
               w_state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            w_stall = 1'b1;
            if (mem_ack || w_timeout) w_state_nxt = RESP;
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_err         <= 1'b0;
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_rdata_valid <= 1'b0;
         r_err         <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_legal) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= memwrite;
                  r_mem_addr  <= addr;
                  r_mem_wdata <= wdata;
               end else if (w_conflict || w_misaligned) begin
                  r_err <= 1'b1;
               end
            end
            ACCESS: begin
               r_cnt <= w_cnt_inc;
               if (mem_ack) begin
                  r_mem_req     <= 1'b0;
                  r_rdata_valid <= 1'b1;
                  if (!r_mem_we) r_rdata <= mem_rdata;
               end else if (w_timeout) begin
                  r_mem_req <= 1'b0;
                  r_err     <= 1'b1;
               end
            end
            RESP:    r_cnt <= '0;
            default: r_cnt <= '0;
         endcase
      end
   end

   assign stall       = w_stall;
   assign rdata       = r_rdata;
   assign rdata_valid = r_rdata_valid;
   assign err         = r_err;
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage consumer of the decoder's memread/memwrite signals.
- Turns a one-cycle load/store request from the pipeline into a req/ack transaction on the data-memory bus.
- Holds the pipeline with stall until the access completes, then returns load data with a one-cycle valid pulse.
- Flags misaligned, conflicting or timed-out accesses as errors.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width.
- TIMEOUT, 255, cycles in ACCESS without mem_ack before a bus error is raised; minimum 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- valid  in  1  MEM stage holds a live instruction
- memread  in  1  load request from control path
- memwrite  in  1  store request from control path
- addr  in  ADDR_WIDTH  byte address (ALU result)
- wdata  in  DATA_WIDTH  store data
- stall  out  1  pipeline hold, combinational
- rdata  out  DATA_WIDTH  load result, registered
- rdata_valid  out  1  one-cycle completion pulse, for loads and stores
- err  out  1  one-cycle error pulse
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  bus address, word aligned
- mem_wdata  out  DATA_WIDTH  bus write data
- mem_ack  in  1  bus completion, one-cycle pulse
- mem_rdata  in  DATA_WIDTH  bus read data, valid with mem_ack

Behaviour:
- Reset values:
  - State is IDLE.
  - mem_req, mem_we, rdata_valid and err are 0.
  - rdata, mem_addr and mem_wdata are 0.
  - The timeout counter is 0.
- A request exists when valid=1 and (memread|memwrite)=1.
- States are IDLE, ACCESS and RESP.
- IDLE, legal request (exactly one of memread/memwrite, addr[1:0]==0):
  - Latch mem_addr=addr, mem_wdata=wdata and mem_we=memwrite.
  - Set mem_req=1 at the edge and go to ACCESS.
  - stall=1 combinationally in this same cycle.
- IDLE, memread and memwrite both 1: err=1 next cycle, no bus access, stall=0, stay IDLE.
- IDLE, addr[1:0]!=0: err=1 next cycle, no bus access, stall=0, stay IDLE.
- IDLE, no request: outputs idle. A stray mem_ack is ignored.
- ACCESS:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable; stall=1.
  - The counter increments each cycle.
  - On mem_ack: capture rdata=mem_rdata (loads only; stores leave rdata unchanged), drop mem_req and go to RESP.
  - When the counter reaches TIMEOUT with no ack: drop mem_req, set err=1 and go to RESP.
  - If mem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins and there is no err.
- RESP:
  - stall=0, so the pipeline advances at this edge.
  - rdata_valid=1 if the access was not a timeout.
  - Clear the counter and go to IDLE.
  - A new request can be accepted from the next cycle; there is no back-to-back acceptance inside RESP.
- Latency: request cycle T; mem_req visible T+1; ack at T+k (k≥1); RESP/rdata_valid at T+k+1. Minimum is 3 cycles per access.
- rdata holds its value until the next load completes.
- Reset mid-ACCESS: mem_req drops at the reset edge and the state returns to IDLE. A late ack afterwards is ignored.
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - the alignment-check mask.
- No sub-module is needed. The timeout counter is inline.

Test Plan:
- Load, ack after 2 cycles: valid=1, memread=1, addr=0x40 at T; mem_ack=1, mem_rdata=0xDEADBEEF at T+2.
  - Required: mem_req=1 at T+1..T+2, mem_addr=0x40, mem_we=0.
  - stall=1 at T..T+2; rdata=0xDEADBEEF and rdata_valid=1 at T+3.
- Store, ack after 1 cycle: memwrite=1, addr=0x10, wdata=0x12345678.
  - Required: mem_we=1 and mem_wdata=0x12345678 held until ack.
  - rdata_valid pulse; rdata unchanged.
- Misaligned load: addr=0x42.
  - Required: err=1 one cycle, mem_req never asserted, stall=0 throughout.
- Timeout: TIMEOUT=4, load with no ack.
  - Required: mem_req dropped after 4 cycles in ACCESS, err=1, rdata_valid=0, back to IDLE.
- Reset mid-access: reset=1 at T+2 of a pending load.
  - Required: mem_req=0 and stall=0 after that edge; an ack at T+3 produces no rdata_valid.
- Conflict plus stray ack: memread=memwrite=1 → err pulse, no bus access. mem_ack pulsed in IDLE → no outputs change.
